// File: rtl/tt_input_conditioner_pkg.sv
// Shared constants and types for the Tiny Tapeout input conditioner.
// Pad bit positions, default debounce length and the io_out payload layout.
package tt_input_conditioner_pkg;

  localparam int unsigned IO_W                = 8;
  localparam int unsigned CLK_BIT             = 0;
  localparam int unsigned RST_BIT             = 1;
  localparam int unsigned RAW_LSB             = 2;
  localparam int unsigned NUM_CH              = 3;
  localparam int unsigned PULSE_BIT           = 3;
  localparam int unsigned CNT_LSB             = 4;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // io_out layout: {count[7:4], pulse[3], level[2:0]}
  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic              pulse;
    logic [NUM_CH-1:0] level;
  } io_out_t;

  // Debounce counter width able to hold 0..n
  function automatic int unsigned dbc_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tt_input_conditioner_if.sv
// Tiny Tapeout 8-in/8-out user-module pad bundle.
// The host side drives io_in and observes io_out; the user module is the reverse.
interface tt_input_conditioner_if;
  import tt_input_conditioner_pkg::*;

  logic [IO_W-1:0] io_in;
  logic [IO_W-1:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);

endinterface

// File: rtl/tt_debounce_chan.sv
// One conditioning channel: 2-FF synchroniser, N-cycle debounce, stable level and rise pulse.
// rise_c_o is the unregistered "level rises on this edge" strobe, for same-edge consumers.
module tt_debounce_chan
  import tt_input_conditioner_pkg::*;
#(
  parameter int unsigned N = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic rise_c_o
);

  localparam int unsigned CW = dbc_cnt_width(N);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any disagreement must persist N consecutive cycles before it is accepted
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(N - 1)) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign rise_c_o = stable_d & ~stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_c_o;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/tt_input_conditioner.sv
// Input conditioner ahead of the AND/OR gate module: three debounced levels, a rise pulse
// and a channel-0 press counter. Counter built only with TT_INCOND_EVENT_COUNT_EN defined.
module tt_input_conditioner
  import tt_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  tt_input_conditioner_if.slave io
);

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] rise_c;
  logic [CNT_W-1:0]  count;
  io_out_t           out_c;
  logic              unused_io;

  assign clk = io.io_in[CLK_BIT];
  assign rst = io.io_in[RST_BIT];
  assign raw = io.io_in[RAW_LSB +: NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    tt_debounce_chan #(
      .N (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw[g]),
      .level_o  (level[g]),
      .rise_o   (rise[g]),
      .rise_c_o (rise_c[g])
    );
  end

`ifdef TT_INCOND_EVENT_COUNT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counts on the same edge the channel-0 rise pulse is set; wraps silently
  always_comb begin
    count_d = count_q;
    if (rise_c[0]) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

  // Pads 7:5 are not connected to anything; only channel 0's early strobe is consumed
  assign unused_io = &{1'b0, io.io_in[IO_W-1:RAW_LSB+NUM_CH], rise_c};

  assign out_c.count = count;
  assign out_c.pulse = |rise;
  assign out_c.level = level;
  assign io.io_out   = out_c;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Directed bench for tt_input_conditioner with N=4; expected io_out values are hand-derived.
// Counter nibble expectations follow TT_INCOND_EVENT_COUNT_EN (zero when undefined).
module tb_tt_input_conditioner;
  import tt_input_conditioner_pkg::*;

`ifdef TT_INCOND_EVENT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] raw;
  int         n_checks;
  int         n_pass;
  int         exp_cnt;

  tt_input_conditioner_if bus ();

  // Unused pads carry a nonzero pattern to show they are ignored
  assign bus.io_in = {3'b101, raw, rst, clk};

  tt_input_conditioner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_out(input logic pulse, input logic [2:0] lvl);
    return {(CNT_EN ? 4'(exp_cnt) : 4'd0), pulse, lvl};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    raw = 3'b111;
    exp_cnt = 0;
    tick(1);
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL reset_edge1: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL reset_edge2: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    rst = 1'b0;
    // Raw high sampled at release edge k=1 -> levels appear at edge 6
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      n_checks++;
      if (bus.io_out !== e) $display("FAIL reset_release_edge%0d: io_out=%h expected %h", i, bus.io_out, e);
      else n_pass++;
    end
    tick(1);
    exp_cnt = 1;
    e = exp_out(1'b1, 3'b111);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL reset_release_rise: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b0, 3'b111);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL reset_pulse_end: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    raw = 3'b000;
    tick(6);
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL reset_fall_no_pulse: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    logic [7:0] e;
    raw[0] = 1'b1;
    tick(5);
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL press_k4: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    exp_cnt++;
    e = exp_out(1'b1, 3'b001);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL press_k5: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b0, 3'b001);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL press_pulse_end: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    raw[0] = 1'b0;
    tick(6);
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL press_release: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [7:0] e;
    int seen;
    seen = 0;
    raw[1] = 1'b1;
    tick(3);
    raw[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.io_out[1] | bus.io_out[3]) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL glitch3_seen: high_cycles=%0d expected 0", seen);
    else n_pass++;
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL glitch3_final: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    // Four-cycle high is just long enough to be accepted at edge k+5
    raw[1] = 1'b1;
    tick(4);
    raw[1] = 1'b0;
    tick(1);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL glitch4_k4: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b1, 3'b010);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL glitch4_rise: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(10);
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL glitch4_settle: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [7:0] e;
    bit seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      raw[0] = seq[i];
      tick(1);
    end
    // Final toggle sampled at k+5; rise expected at k+10
    tick(4);
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL bounce_k9: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    exp_cnt++;
    e = exp_out(1'b1, 3'b001);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL bounce_k10: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b0, 3'b001);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL bounce_single: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    raw[0] = 1'b0;
    tick(6);
  endtask

  task automatic test_wrap_simultaneous();
    logic [7:0] e;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_cnt = 0;
    for (int p = 1; p <= 16; p++) begin
      raw[0] = 1'b1;
      tick(6);
      exp_cnt++;
      raw[0] = 1'b0;
      tick(6);
      if (p == 15) begin
        e = exp_out(1'b0, 3'b000);
        n_checks++;
        if (bus.io_out !== e) $display("FAIL wrap_15: io_out=%h expected %h", bus.io_out, e);
        else n_pass++;
      end
    end
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== e || bus.io_out[7:4] !== 4'd0)
      $display("FAIL wrap_16: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    raw = 3'b101;
    tick(5);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL simul_k4: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    exp_cnt++;
    e = exp_out(1'b1, 3'b101);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL simul_rise: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b0, 3'b101);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL simul_single: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    raw = 3'b000;
    tick(6);
  endtask

  task automatic test_mid_debounce_reset();
    logic [7:0] e;
    raw[2] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    exp_cnt = 0;
    e = exp_out(1'b0, 3'b000);
    n_checks++;
    if (bus.io_out !== 8'h00) $display("FAIL midrst_cleared: io_out=%h expected 00", bus.io_out);
    else n_pass++;
    rst = 1'b0;
    tick(5);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL midrst_k4: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b1, 3'b100);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL midrst_rise: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
    tick(1);
    e = exp_out(1'b0, 3'b100);
    n_checks++;
    if (bus.io_out !== e) $display("FAIL midrst_pulse_end: io_out=%h expected %h", bus.io_out, e);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 0;
    rst      = 1'b1;
    raw      = 3'b000;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_wrap_simultaneous();
    test_mid_debounce_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
